relu_argmax_ctrl: RTL and testbench



---
 rtl/relu_argmax_ctrl.sv | 114 +++++++++++
 tb/tb_relu_argmax_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/relu_argmax_ctrl.sv
// rtl/relu_argmax_ctrl.sv - ReLU score buffer and argmax sequencer for the classifier stage
module relu_argmax_ctrl #(
  parameter int bitwidth = 16,
  parameter int N_CLASS  = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [bitwidth-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          class_idx,
  output logic [bitwidth-1:0] class_score,
  output logic [bitwidth-1:0] featuremap_RELUed [N_CLASS-1:0],
  output logic                busy
);

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    SCAN = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(N_CLASS - 1);

  state_t              state;
  state_t              state_nx;
  logic [3:0]          cnt;
  logic [bitwidth-1:0] fm_buf [N_CLASS-1:0];
  logic [bitwidth-1:0] best_val;
  logic [3:0]          best_idx;
  logic [bitwidth-1:0] relu_data;
  logic                in_acc;
  logic                out_acc;
  logic                cnt_last;

  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;
  assign cnt_last  = (cnt == LAST);
  // Negative scores clamp to zero; positive scores pass through at full width.
  assign relu_data = in_data[bitwidth-1] ? '0 : in_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nx;
  end

  // Next-state decode: a frame is 10 accepts, 10 scan steps, one output handshake
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_acc && cnt_last) state_nx = SCAN;
      SCAN:    if (cnt_last)           state_nx = OUT;
      OUT:     if (out_acc)            state_nx = LOAD;
      default:                         state_nx = LOAD;
    endcase
  end

  // Handshake outputs decode straight from the state register; in_ready is also held low in reset
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      LOAD:    in_ready  = !rst;
      SCAN:    busy      = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: shared counter, ReLU buffer writes in LOAD, running maximum in SCAN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
      for (int i = 0; i < N_CLASS; i++) fm_buf[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_acc) begin
            fm_buf[cnt] <= relu_data;
            cnt         <= cnt_last ? 4'd0 : cnt + 4'd1;
          end
        end
        SCAN: begin
          // Strict greater-than keeps the lowest index on ties.
          if (cnt == 4'd0) begin
            best_val <= fm_buf[0];
            best_idx <= 4'd0;
          end else if ($signed(fm_buf[cnt]) > $signed(best_val)) begin
            best_val <= fm_buf[cnt];
            best_idx <= cnt;
          end
          cnt <= cnt_last ? 4'd0 : cnt + 4'd1;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign class_idx         = best_idx;
  assign class_score       = best_val;
  assign featuremap_RELUed = fm_buf;

endmodule

// File: tb/tb_relu_argmax_ctrl.sv
// tb/tb_relu_argmax_ctrl.sv - directed self-checking bench for relu_argmax_ctrl
module tb_relu_argmax_ctrl;

  localparam int W = 16;
  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [3:0]   class_idx;
  logic [W-1:0] class_score;
  logic [W-1:0] featuremap_RELUed [N-1:0];
  logic         busy;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] fa  [N];
  logic [W-1:0] fn  [N];
  logic [W-1:0] ft  [N];
  logic [W-1:0] fm  [N];
  logic [W-1:0] fb  [N];
  logic [W-1:0] fr  [N];

  relu_argmax_ctrl #(.bitwidth(W), .N_CLASS(N)) dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .class_idx        (class_idx),
    .class_score      (class_score),
    .featuremap_RELUed(featuremap_RELUed),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] relu(input logic [W-1:0] v);
    return v[W-1] ? '0 : v;
  endfunction

  // Drives n beats; gaps randomly idles in_valid with junk on in_data.
  task automatic send_frame(input logic [W-1:0] v [N], input int n, input bit gaps, output int nacc);
    bit acc;
    int guard;
    nacc  = 0;
    guard = 0;
    while (nacc < n && guard < 400) begin
      @(negedge clk);
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? v[nacc] : 16'hBEEF;
      acc      = in_valid && in_ready;
      @(posedge clk);
      if (acc) nacc++;
      guard++;
    end
    #1;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  // Counts negedges after the last accept edge; k=11 means cycle T+11.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic check_fm(input string tag, input logic [W-1:0] v [N]);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_fm%0d", tag, i), 32'(featuremap_RELUed[i]), 32'(relu(v[i])));
  endtask

  task automatic run_frame(input string tag, input logic [W-1:0] v [N], input bit gaps,
                           input logic [3:0] e_idx, input logic [W-1:0] e_score);
    int nacc;
    int lat;
    send_frame(v, N, gaps, nacc);
    chk({tag, "_accepts"}, 32'(nacc), 32'd10);
    wait_result(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd11);
    chk({tag, "_idx"}, 32'(class_idx), 32'(e_idx));
    chk({tag, "_score"}, 32'(class_score), 32'(e_score));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    check_fm(tag, v);
    @(negedge clk);
    chk({tag, "_valid_1cyc"}, 32'(out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int nacc;
    int lat;

    fa = '{16'd5, 16'hFFFD, 16'd12, 16'd7, 16'd0, 16'hFF9C, 16'd11, 16'd2, 16'd9, 16'd1};
    fn = '{default: 16'hFFFF};
    ft = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd3, 16'd1, 16'd1, 16'd1, 16'd3, 16'd1};
    fm = '{16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'd100, 16'h7FFF};
    fb = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80, 16'd90, 16'hFFFB};
    fr = '{16'h0100, 16'h7000, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010, 16'h0010};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(class_idx), 32'd0);
    chk("rst_score", 32'(class_score), 32'd0);
    chk("rst_fm0", 32'(featuremap_RELUed[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    run_frame("basic", fa, 1'b0, 4'd2, 16'd12);
    run_frame("allneg", fn, 1'b0, 4'd0, 16'd0);
    run_frame("tie", ft, 1'b0, 4'd4, 16'd3);
    run_frame("maxpos", fm, 1'b0, 4'd9, 16'h7FFF);

    // Backpressure: result held while in_valid pulses are ignored.
    out_ready = 1'b0;
    send_frame(fb, N, 1'b0, nacc);
    wait_result(lat);
    chk("bp_latency", 32'(lat), 32'd11);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'(i % 2);
      in_data  = 16'h7FFF;
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_idx", 32'(class_idx), 32'd8);
      chk("bp_score", 32'(class_score), 32'd90);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    check_fm("bp_hold", fb);
    run_frame("bp_next", ft, 1'b0, 4'd4, 16'd3);

    run_frame("gaps", fa, 1'b1, 4'd2, 16'd12);

    // Async reset mid-LOAD after 6 beats of large values.
    send_frame(fr, 6, 1'b0, nacc);
    chk("load6_fm1", 32'(featuremap_RELUed[1]), 32'h7000);
    #2 rst = 1'b1;
    #1;
    chk("rl_in_ready", 32'(in_ready), 32'd0);
    chk("rl_fm1", 32'(featuremap_RELUed[1]), 32'd0);
    chk("rl_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame("after_rl", fa, 1'b0, 4'd2, 16'd12);

    // Async reset mid-SCAN once a nonzero running best exists.
    send_frame(fr, N, 1'b0, nacc);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("scan_busy", 32'(busy), 32'd1);
    chk("scan_best_idx", 32'(class_idx), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_out_valid", 32'(out_valid), 32'd0);
    chk("rs_in_ready", 32'(in_ready), 32'd0);
    chk("rs_idx", 32'(class_idx), 32'd0);
    chk("rs_score", 32'(class_score), 32'd0);
    chk("rs_fm1", 32'(featuremap_RELUed[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rs_ready_back", 32'(in_ready), 32'd1);
    run_frame("after_rs", ft, 1'b0, 4'd4, 16'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
